// File: rtl/snitch_sb_retire_pkg.sv
// Shared types and helpers for the FP scoreboard retirement block.
package snitch_sb_retire_pkg;

  // Trace source tags; SrcFpuSbRetire marks events from the retirement stage.
  typedef enum logic [2:0] {
    SrcSnitch      = 3'd0,
    SrcFpu         = 3'd1,
    SrcFpuSeq      = 3'd2,
    SrcFpuSbRetire = 3'd3
  } trace_src_e;

  // Widest scoreboard index the one-hot helper handles.
  localparam int unsigned MaxIdxWidth = 32;

  // True when exactly one bit of the vector is set (all-zero is not one-hot).
  function automatic logic is_onehot(input logic [MaxIdxWidth-1:0] vec);
    return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/snitch_sb_retire_if.sv
// Completion channel from the result producers into the retirement stage.
interface snitch_sb_retire_if #(
  parameter int unsigned NumSrc    = 2,
  parameter int unsigned Depth     = 4,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 64
);
  logic [NumSrc-1:0]                valid;
  logic [NumSrc-1:0]                ready;
  logic [NumSrc-1:0][Depth-1:0]     index;
  logic [NumSrc-1:0][AddrWidth-1:0] rd;
  logic [NumSrc-1:0][DataWidth-1:0] data;

  modport master (output valid, index, rd, data, input ready);
  modport slave  (input valid, index, rd, data, output ready);
endinterface

// File: rtl/snitch_sb_retire_fifo.sv
// Small retirement FIFO; exposes the OR of all stored scoreboard indices.
// The index field occupies the top IdxWidth bits of each entry.
module snitch_sb_retire_fifo #(
  parameter int unsigned Width    = 8,
  parameter int unsigned Depth    = 2,
  parameter int unsigned IdxWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [Width-1:0]    data_o,
  output logic [IdxWidth-1:0] inflight_o
);
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]    mem_q [Depth];
  logic [Depth-1:0]    valid_q, valid_d;
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(Depth - 1)) begin
      return {PtrWidth{1'b0}};
    end else begin
      return p + PtrWidth'(1'b1);
    end
  endfunction

  // Slot occupancy and pointer update; a pop frees its slot before a push refills.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Storage, occupancy and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= {Width{1'b0}};
      valid_q  <= {Depth{1'b0}};
      wr_ptr_q <= {PtrWidth{1'b0}};
      rd_ptr_q <= {PtrWidth{1'b0}};
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // OR of the scoreboard indices held in occupied slots.
  always_comb begin
    inflight_o = {IdxWidth{1'b0}};
    for (int i = 0; i < Depth; i++) begin
      if (valid_q[i]) begin
        inflight_o = inflight_o | mem_q[i][Width-1 -: IdxWidth];
      end else begin
        inflight_o = inflight_o;
      end
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = ~|valid_q;
  assign full_o  = &valid_q;

endmodule

// File: rtl/snitch_sb_retire.sv
// Retirement end of the FPU scoreboard: arbitrates completions, queues them,
// writes the FP register file and frees the scoreboard entry on each write.
module snitch_sb_retire
  import snitch_sb_retire_pkg::*;
#(
  parameter int unsigned Depth     = 4,
  parameter int unsigned NumSrc    = 2,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  snitch_sb_retire_if.slave    src,
  output logic                 rf_wvalid_o,
  input  logic                 rf_wready_i,
  output logic [AddrWidth-1:0] rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic [Depth-1:0]     pop_index_o,
  output logic                 pop_valid_o,
  output logic                 busy_o,
  output logic                 err_o
);
  localparam int unsigned SrcWidth = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  typedef struct packed {
    logic [Depth-1:0]     index;
    logic [AddrWidth-1:0] rd;
    logic [DataWidth-1:0] data;
  } entry_t;

  logic [SrcWidth-1:0] ptr_q, ptr_d, grant_s;
  logic                grant_valid_s, push_s, pop_s, full_s, empty_s;
  logic                err_d, err_q;
  logic [Depth-1:0]    inflight_s;
  entry_t              push_entry_s, head_s;
  int unsigned         cand_s;

  // Round-robin search for the first valid source at or after the pointer.
  always_comb begin
    grant_s       = ptr_q;
    grant_valid_s = 1'b0;
    cand_s        = 32'd0;
    for (int unsigned off = 0; off < NumSrc; off++) begin
      cand_s = 32'(ptr_q) + off;
      cand_s = (cand_s >= NumSrc) ? cand_s - NumSrc : cand_s;
      if (src.valid[cand_s] && !grant_valid_s) begin
        grant_s       = SrcWidth'(cand_s);
        grant_valid_s = 1'b1;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Ready goes to the granted source only, and only on a registered free slot;
  // nothing is accepted while reset is held.
  always_comb begin
    src.ready = {NumSrc{1'b0}};
    if (rst_ni && grant_valid_s && !full_s) begin
      src.ready[grant_s] = 1'b1;
    end else begin
      src.ready = {NumSrc{1'b0}};
    end
  end

  assign push_s             = |(src.valid & src.ready);
  assign push_entry_s.index = src.index[grant_s];
  assign push_entry_s.rd    = src.rd[grant_s];
  assign push_entry_s.data  = src.data[grant_s];

  // Pointer advances past the granted source on a handshake; flag bad or duplicate indices.
  always_comb begin
    if (push_s) begin
      ptr_d = (grant_s == SrcWidth'(NumSrc - 1)) ? {SrcWidth{1'b0}} : grant_s + SrcWidth'(1'b1);
    end else begin
      ptr_d = ptr_q;
    end
    err_d = push_s && (!is_onehot(MaxIdxWidth'(push_entry_s.index)) ||
                       (|(push_entry_s.index & inflight_s)));
  end

  // Arbitration pointer and error pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= {SrcWidth{1'b0}};
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  snitch_sb_retire_fifo #(
    .Width    ($bits(entry_t)),
    .Depth    (FifoDepth),
    .IdxWidth (Depth)
  ) i_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push_s),
    .data_i     (push_entry_s),
    .pop_i      (pop_s),
    .full_o     (full_s),
    .empty_o    (empty_s),
    .data_o     (head_s),
    .inflight_o (inflight_s)
  );

  // Register-file write and scoreboard free driven from the FIFO head.
  always_comb begin
    pop_s       = !empty_s && rf_wready_i;
    rf_wvalid_o = !empty_s;
    busy_o      = !empty_s;
    pop_valid_o = pop_s;
    if (!empty_s) begin
      rf_waddr_o = head_s.rd;
      rf_wdata_o = head_s.data;
    end else begin
      rf_waddr_o = {AddrWidth{1'b0}};
      rf_wdata_o = {DataWidth{1'b0}};
    end
    // A malformed index must never free scoreboard entries.
    if (pop_s && is_onehot(MaxIdxWidth'(head_s.index))) begin
      pop_index_o = head_s.index;
    end else begin
      pop_index_o = {Depth{1'b0}};
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_snitch_sb_retire.sv
// Directed self-checking bench for snitch_sb_retire.
module tb_snitch_sb_retire;
  localparam int unsigned Depth     = 4;
  localparam int unsigned NumSrc    = 2;
  localparam int unsigned AddrWidth = 5;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned FifoDepth = 2;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic                 rf_wvalid, rf_wready;
  logic [AddrWidth-1:0] rf_waddr;
  logic [DataWidth-1:0] rf_wdata;
  logic [Depth-1:0]     pop_index;
  logic                 pop_valid, busy, err;

  int n_checks = 0;
  int n_errors = 0;

  snitch_sb_retire_if #(
    .NumSrc(NumSrc), .Depth(Depth), .AddrWidth(AddrWidth), .DataWidth(DataWidth)
  ) src_if ();

  snitch_sb_retire #(
    .Depth(Depth), .NumSrc(NumSrc), .AddrWidth(AddrWidth),
    .DataWidth(DataWidth), .FifoDepth(FifoDepth)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .src         (src_if),
    .rf_wvalid_o (rf_wvalid),
    .rf_wready_i (rf_wready),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata),
    .pop_index_o (pop_index),
    .pop_valid_o (pop_valid),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [3:0] idx, input logic [4:0] rd, input logic [63:0] data);
    src_if.index[k] = idx;
    src_if.rd[k]    = rd;
    src_if.data[k]  = data;
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    src_if.valid = 2'b00;
    rf_wready    = 1'b1;
    tick();
    rst_ni = 1'b1;
  endtask

  logic [Depth-1:0]     exp_idx_q[$];
  logic [AddrWidth-1:0] exp_rd_q[$];
  logic [7:0]           bp_wready = 8'b1110_0000;
  logic [7:0]           bp_ready  = 8'b1100_0011;
  logic [7:0]           bp_wvalid = 8'b1111_1110;
  logic [3:0]           bp_pidx [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                        4'b0000, 4'b0001, 4'b0010, 4'b0100};

  initial begin
    int c0, c1, turn, j;

    // Reset state, with both sources already requesting.
    rst_ni       = 1'b0;
    rf_wready    = 1'b1;
    src_if.valid = 2'b11;
    set_src(0, 4'b0001, 5'd1, 64'h1);
    set_src(1, 4'b0010, 5'd2, 64'h2);
    #3;
    check_eq("rst_ready",     src_if.ready, 2'b00);
    check_eq("rst_wvalid",    rf_wvalid, 1'b0);
    check_eq("rst_waddr",     rf_waddr, 5'd0);
    check_eq("rst_wdata",     rf_wdata, 64'd0);
    check_eq("rst_pop_valid", pop_valid, 1'b0);
    check_eq("rst_pop_index", pop_index, 4'b0000);
    check_eq("rst_busy",      busy, 1'b0);
    check_eq("rst_err",       err, 1'b0);
    do_reset();

    // Single retire: one-cycle latency, pop in the same cycle as the write.
    src_if.valid = 2'b01;
    set_src(0, 4'b0010, 5'd5, 64'hABCD);
    #1;
    check_eq("single_ready",   src_if.ready, 2'b01);
    check_eq("single_nocomb",  rf_wvalid, 1'b0);
    tick();
    src_if.valid = 2'b00;
    #1;
    check_eq("single_wvalid",  rf_wvalid, 1'b1);
    check_eq("single_waddr",   rf_waddr, 5'd5);
    check_eq("single_wdata",   rf_wdata, 64'hABCD);
    check_eq("single_popv",    pop_valid, 1'b1);
    check_eq("single_popidx",  pop_index, 4'b0010);
    check_eq("single_err",     err, 1'b0);
    tick();
    check_eq("single_busy",    busy, 1'b0);

    // Round-robin: both sources continuously valid, 4 completions each.
    do_reset();
    c0 = 0; c1 = 0; turn = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      src_if.valid = {c1 < 4, c0 < 4};
      set_src(0, 4'b0001, 5'(c0), 64'h1000 + 64'(c0));
      set_src(1, 4'b0010, 5'(16 + c1), 64'h2000 + 64'(c1));
      #1;
      if (exp_idx_q.size() > 0) begin
        check_eq("rr_pop_valid", pop_valid, 1'b1);
        check_eq("rr_pop_index", pop_index, exp_idx_q.pop_front());
        check_eq("rr_waddr",     rf_waddr, exp_rd_q.pop_front());
      end else begin
        check_eq("rr_pop_idle", pop_valid, 1'b0);
      end
      if (c0 < 4 || c1 < 4) begin
        check_eq("rr_grant", src_if.ready, (turn == 0) ? 2'b01 : 2'b10);
        if (turn == 0) begin
          exp_idx_q.push_back(4'b0001); exp_rd_q.push_back(5'(c0)); c0++;
        end else begin
          exp_idx_q.push_back(4'b0010); exp_rd_q.push_back(5'(16 + c1)); c1++;
        end
        turn ^= 1;
      end
      tick();
    end
    check_eq("rr_err",  err, 1'b0);
    check_eq("rr_busy", busy, 1'b0);

    // Backpressure: RF stalled 5 cycles, FIFO fills at 2, then drains and resumes.
    do_reset();
    j = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      rf_wready    = bp_wready[cyc];
      src_if.valid = 2'b01;
      set_src(0, 4'b0001 << j, 5'(j), 64'hB0 + 64'(j));
      #1;
      check_eq("bp_ready",     src_if.ready, {1'b0, bp_ready[cyc]});
      check_eq("bp_wvalid",    rf_wvalid, bp_wvalid[cyc]);
      check_eq("bp_pop_valid", pop_valid, bp_wready[cyc] & bp_wvalid[cyc]);
      check_eq("bp_pop_index", pop_index, bp_pidx[cyc]);
      check_eq("bp_err",       err, 1'b0);
      if (bp_ready[cyc]) j++;
      tick();
    end
    src_if.valid = 2'b00;
    #1;
    check_eq("bp_last_pop",   pop_index, 4'b1000);
    check_eq("bp_last_waddr", rf_waddr, 5'd3);
    tick();
    check_eq("bp_busy", busy, 1'b0);

    // Duplicate index while the same index sits at the head.
    do_reset();
    rf_wready    = 1'b0;
    src_if.valid = 2'b01;
    set_src(0, 4'b0100, 5'd1, 64'h11);
    tick();
    set_src(0, 4'b0100, 5'd2, 64'h22);
    #1;
    check_eq("dup_ready", src_if.ready, 2'b01);
    check_eq("dup_err0",  err, 1'b0);
    tick();
    src_if.valid = 2'b00;
    rf_wready    = 1'b1;
    #1;
    check_eq("dup_err1",   err, 1'b1);
    check_eq("dup_pop1",   pop_index, 4'b0100);
    check_eq("dup_waddr1", rf_waddr, 5'd1);
    tick();
    check_eq("dup_err2",   err, 1'b0);
    check_eq("dup_pop2",   pop_index, 4'b0100);
    check_eq("dup_wdata2", rf_wdata, 64'h22);
    tick();
    check_eq("dup_busy", busy, 1'b0);

    // Malformed index: written to the RF, but frees nothing.
    do_reset();
    src_if.valid = 2'b10;
    set_src(1, 4'b0110, 5'd9, 64'h55);
    #1;
    check_eq("bad_ready", src_if.ready, 2'b10);
    tick();
    src_if.valid = 2'b00;
    #1;
    check_eq("bad_err",    err, 1'b1);
    check_eq("bad_waddr",  rf_waddr, 5'd9);
    check_eq("bad_wdata",  rf_wdata, 64'h55);
    check_eq("bad_popv",   pop_valid, 1'b1);
    check_eq("bad_popidx", pop_index, 4'b0000);
    tick();
    check_eq("bad_err_end", err, 1'b0);
    check_eq("bad_busy",    busy, 1'b0);

    // Asynchronous reset mid-cycle with two entries queued.
    do_reset();
    rf_wready    = 1'b0;
    src_if.valid = 2'b01;
    set_src(0, 4'b0001, 5'd7, 64'h77);
    tick();
    set_src(0, 4'b0010, 5'd8, 64'h88);
    tick();
    src_if.valid = 2'b00;
    rf_wready    = 1'b1;
    #1;
    check_eq("ar_pre_popv", pop_valid, 1'b1);
    check_eq("ar_pre_busy", busy, 1'b1);
    #1;
    rst_ni = 1'b0;
    #1;
    check_eq("ar_wvalid", rf_wvalid, 1'b0);
    check_eq("ar_busy",   busy, 1'b0);
    check_eq("ar_popv",   pop_valid, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    check_eq("ar_stale1", rf_wvalid, 1'b0);
    tick();
    check_eq("ar_stale2", rf_wvalid, 1'b0);
    check_eq("ar_stale_popv", pop_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/snitch_sb_retire.md
# snitch_sb_retire

Retirement end of the FPU scoreboard protocol. Collects completion tags from several result producers (FPU pipeline, FP load path), each carrying the one-hot scoreboard index allocated at issue, the destination register and the result data. Serialises them through a small FIFO into the FP register-file write port. On each accepted register-file write, frees the matching scoreboard entry by driving its one-hot pop index.

## Interface
Parameters:
- Depth, 4: scoreboard entries; width of the one-hot index.
- NumSrc, 2: number of completion sources.
- AddrWidth, 5: register address width.
- DataWidth, 64: result data width.
- FifoDepth, 2: retirement FIFO entries; must be ≥ 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- src_valid_i  in  NumSrc  completion valid per source.
- src_ready_o  out  NumSrc  completion accepted (handshake on valid & ready).
- src_index_i  in  NumSrc×Depth  one-hot scoreboard index per source.
- src_rd_i  in  NumSrc×AddrWidth  destination register per source.
- src_data_i  in  NumSrc×DataWidth  result data per source.
- rf_wvalid_o  out  1  register-file write request.
- rf_wready_i  in  1  register-file write accepted.
- rf_waddr_o  out  AddrWidth  write address.
- rf_wdata_o  out  DataWidth  write data.
- pop_index_o  out  Depth  one-hot index of the entry to free.
- pop_valid_o  out  1  free request to the scoreboard.
- busy_o  out  1  FIFO non-empty.
- err_o  out  1  one-cycle pulse on a protocol violation.

## Operation
- Arbitration: round-robin over sources with src_valid_i high.
  - Priority pointer starts at source 0 after reset.
  - After a handshake, the pointer moves to the source after the granted one.
  - The pointer does not move if there is no handshake.
- src_ready_o[k] is high only when source k is granted and the FIFO count < FifoDepth. At most one source is ready per cycle.
- Accepted completion {index, rd, data} is pushed into the FIFO.
- Outputs are driven from the FIFO head:
  - rf_wvalid_o = FIFO non-empty.
  - rf_waddr_o and rf_wdata_o come from the head entry.
- On rf_wvalid_o & rf_wready_i:
  - The head is popped.
  - pop_valid_o = 1 and pop_index_o = head index in the same cycle.
  - Otherwise pop_valid_o = 0 and pop_index_o = 0.
- At most one pop per cycle. pop_index_o is always zero or exactly one-hot.
- In-flight mask: the OR of the indices of all FIFO entries.
- err_o pulses in the cycle of an accepted completion whose index is not one-hot, or overlaps the in-flight mask (duplicate retirement). The entry is still accepted.
  - A non-one-hot index entry is written to the register file but its pop index is forced to 0.
- Simultaneous push and pop: both take effect; count unchanged.
- A full FIFO does not accept a push in the same cycle as a head pop. Ready depends only on registered count, which keeps rf_wready_i out of the src_ready_o path.
- Reset (asynchronous, any time): FIFO emptied, pointer cleared. Completions in flight are lost; the scoreboard must be reset together with this block.

## Timing
- Reset values: src_ready_o = 0 while reset is asserted, and after release whenever no source is valid. rf_wvalid_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, pop_valid_o = 0, pop_index_o = 0, busy_o = 0, err_o = 0.
- Latency: a completion accepted at edge N gives rf_wvalid_o high in cycle N+1. This is the minimum; there is no combinational source→RF path.
- pop_valid_o is combinational from the FIFO head and rf_wready_i; the scoreboard registers it.
- Throughput: one retirement per cycle with FifoDepth ≥ 2 and rf_wready_i held high.
- With FifoDepth = 1, throughput is one retirement per two cycles.
- Sources must hold valid and payload stable until ready (AXI-style). Dropping valid without a handshake is allowed and does not move the pointer.
- err_o is registered: high in cycle N+1 for a violation accepted at edge N.

## Structure
- The FIFO is a natural sub-module: snitch_sb_retire_fifo.
  - Parameters: entry width, depth.
  - Ports: push/pop, full/empty, head data, OR-reduced in-flight index mask output.
- The round-robin arbiter is inline, roughly 30 lines.
- The entry struct {index, rd, data} is parameter-dependent and is defined locally. Add only SrcFpuSbRetire to the trace-source enum in snitch_pkg.
- Total roughly 200–300 lines.

## Test plan
- Single retire: src0 index 4'b0010, rd 5, data 0xABCD, rf_wready_i = 1 → rf_wvalid_o at N+1 with waddr 5, wdata 0xABCD; pop_valid_o = 1, pop_index_o = 4'b0010 in the same cycle; busy_o then 0.
- Round-robin: both sources valid continuously, 4 completions each → grants alternate 0,1,0,1,…; 8 pops, indices match the accepted order.
- Backpressure: rf_wready_i = 0 for 5 cycles, FifoDepth = 2 → exactly 2 accepted, then src_ready_o = 0. Release → 2 pops over 2 cycles, then acceptance resumes.
- Duplicate: index 4'b0100 accepted while 4'b0100 is at the FIFO head → err_o pulses once; both entries are written and popped in order.
- Bad index 4'b0110 → err_o pulses; the RF write occurs; pop_valid_o = 1 with pop_index_o = 0 for that entry.
- Async reset with 2 entries queued (rst_ni low mid-cycle) → rf_wvalid_o, busy_o and pop_valid_o drop immediately. After release, no stale write appears.
